// File: rtl/vector_memory_sequencer.sv
// Vector memory sequencer: moves vector load/store lanes one at a time over a single-element memory port.
// Optional define VMEM_STRIDE_EN enables strided lane addressing (base + lane*stride); default is unit stride.
module vector_memory_sequencer #(
   parameter int LANES        = 4,
   parameter int DATAWIDTH    = 8,
   parameter int ADDRESSWIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          startM,
   input  logic                          writeM,
   input  logic [ADDRESSWIDTH-1:0]       baseAddressM,
   input  logic [ADDRESSWIDTH-1:0]       strideM,
   input  logic [LANES*DATAWIDTH-1:0]    vectorWriteDataM,
   input  logic                          memReady,
   input  logic                          memReadValid,
   input  logic [DATAWIDTH-1:0]          memReadData,
   output logic                          memRequest,
   output logic                          memWriteEnable,
   output logic [ADDRESSWIDTH-1:0]       memAddress,
   output logic [DATAWIDTH-1:0]          memWriteData,
   output logic [LANES*DATAWIDTH-1:0]    vectorReadDataWB,
   output logic                          doneM,
   output logic                          stallM
);

   localparam int LW = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_READ = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t                       state_r, state_s;
   logic [LW-1:0]                lane_r, lane_s;
   logic                         write_r;
   logic [ADDRESSWIDTH-1:0]      base_r;
   logic [LANES*DATAWIDTH-1:0]   wdata_r;
   logic [LANES*DATAWIDTH-1:0]   rdata_r;
   logic [ADDRESSWIDTH-1:0]      addr_s;
   logic                         req_s, we_s, done_s, stall_s, last_s;

`ifdef VMEM_STRIDE_EN
   logic [ADDRESSWIDTH-1:0]      stride_r;
   assign addr_s = base_r + (ADDRESSWIDTH'(lane_r) * stride_r);
`else
   logic                         unused_stride_s;
   assign unused_stride_s = ^strideM;
   assign addr_s = base_r + ADDRESSWIDTH'(lane_r);
`endif

   assign last_s = (lane_r == LW'(LANES-1));

   // State and lane counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         lane_r  <= '0;
      end else begin
         state_r <= state_s;
         lane_r  <= lane_s;
      end
   end

   // Operand capture at start and lane-wise assembly of the load result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_r  <= 1'b0;
         base_r   <= '0;
         wdata_r  <= '0;
         rdata_r  <= '0;
`ifdef VMEM_STRIDE_EN
         stride_r <= '0;
`endif
      end else begin
         if ((state_r == IDLE) && startM) begin
            write_r  <= writeM;
            base_r   <= baseAddressM;
            wdata_r  <= vectorWriteDataM;
`ifdef VMEM_STRIDE_EN
            stride_r <= strideM;
`endif
         end
         if ((state_r == WAIT_READ) && memReadValid) begin
            rdata_r[lane_r*DATAWIDTH +: DATAWIDTH] <= memReadData;
         end
      end
   end

   // Next-state, lane advance and handshake outputs
   always_comb begin
      state_s = state_r;
      lane_s  = lane_r;
      req_s   = 1'b0;
      we_s    = 1'b0;
      done_s  = 1'b0;
      stall_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (startM) begin
               stall_s = 1'b1;
               lane_s  = '0;
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            req_s   = 1'b1;
            we_s    = write_r;
            stall_s = 1'b1;
            if (memReady) begin
               if (!write_r) begin
                  state_s = WAIT_READ;
               end else if (last_s) begin
                  state_s = DONE;
               end else begin
                  lane_s  = lane_r + LW'(1);
               end
            end else begin
               state_s = ISSUE;
            end
         end
         WAIT_READ: begin
            stall_s = 1'b1;
            if (memReadValid) begin
               if (last_s) begin
                  state_s = DONE;
               end else begin
                  lane_s  = lane_r + LW'(1);
                  state_s = ISSUE;
               end
            end else begin
               state_s = WAIT_READ;
            end
         end
         DONE: begin
            // startM is deliberately not sampled here: the pipeline advances this cycle
            done_s  = 1'b1;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            lane_s  = '0;
         end
      endcase
   end

   assign memRequest       = req_s;
   assign memWriteEnable   = we_s;
   assign memAddress       = req_s ? addr_s : '0;
   assign memWriteData     = req_s ? wdata_r[lane_r*DATAWIDTH +: DATAWIDTH] : '0;
   assign vectorReadDataWB = rdata_r;
   assign doneM            = done_s;
   assign stallM           = stall_s & rst_n;

endmodule

// File: tb/tb_vector_memory_sequencer.sv
// Self-checking bench for vector_memory_sequencer: directed test-plan cases plus randomized
// operations, each checked cycle by cycle against an expected lane schedule.
module tb_vector_memory_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        startM, writeM;
   logic [31:0] baseAddressM, strideM, vectorWriteDataM;
   logic        memReady, memReadValid;
   logic [7:0]  memReadData;
   logic        memRequest, memWriteEnable;
   logic [31:0] memAddress;
   logic [7:0]  memWriteData;
   logic [31:0] vectorReadDataWB;
   logic        doneM, stallM;

   int          errors = 0;
   int          checks = 0;

   int          ready_lo [4];
   int          rd_lat   [4];
   logic [7:0]  rd_byte  [4];
   logic [31:0] seen_addr[4];
   logic [7:0]  seen_data[4];
   logic [31:0] exp_vrd = 32'h0;

   vector_memory_sequencer #(.LANES(4), .DATAWIDTH(8), .ADDRESSWIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .startM(startM), .writeM(writeM),
      .baseAddressM(baseAddressM), .strideM(strideM), .vectorWriteDataM(vectorWriteDataM),
      .memReady(memReady), .memReadValid(memReadValid), .memReadData(memReadData),
      .memRequest(memRequest), .memWriteEnable(memWriteEnable), .memAddress(memAddress),
      .memWriteData(memWriteData), .vectorReadDataWB(vectorReadDataWB),
      .doneM(doneM), .stallM(stallM)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lane_addr(input logic [31:0] b, input logic [31:0] s, input int i);
`ifdef VMEM_STRIDE_EN
      return b + s * 32'(i);
`else
      return b + 32'(i) + (s & 32'h0);
`endif
   endfunction

   task automatic scramble();
      baseAddressM     = $urandom;
      strideM          = $urandom;
      vectorWriteDataM = $urandom;
      writeM           = 1'($urandom_range(1, 0));
   endtask

   task automatic abort_now();
      startM = 1'b0;
      rst_n  = 1'b0;
      #1;
      exp_vrd = 32'h0;
      chk_eq("abort_req",   memRequest,       1'b0);
      chk_eq("abort_stall", stallM,           1'b0);
      chk_eq("abort_done",  doneM,            1'b0);
      chk_eq("abort_vrd",   vectorReadDataWB, exp_vrd);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One vector operation; the bench plays memory following ready_lo/rd_lat/rd_byte.
   task automatic run_op(input logic wr, input logic [31:0] base, input logic [31:0] stride,
                         input logic [31:0] wdata, input bit hold_start, input int abort_lane);
      int          stall_cnt;
      int          exp_stall;
      logic [31:0] new_vrd;
      logic [31:0] addr;
      stall_cnt = 0;
      exp_stall = 0;
      new_vrd   = exp_vrd;
      for (int i = 0; i < 4; i++) exp_stall += ready_lo[i] + 1 + (wr ? 0 : rd_lat[i]);

      @(negedge clk);
      startM = 1'b1; writeM = wr; baseAddressM = base; strideM = stride; vectorWriteDataM = wdata;
      memReady = 1'($urandom_range(1, 0)); memReadValid = 1'($urandom_range(1, 0)); memReadData = $urandom;
      #1;
      chk_eq("start_stall", stallM, 1'b1);
      chk_eq("start_req",   memRequest, 1'b0);

      for (int i = 0; i < 4; i++) begin
         addr = lane_addr(base, stride, i);
         for (int c = 0; c <= ready_lo[i]; c++) begin
            @(negedge clk);
            scramble();
            startM = hold_start;
            memReady = (c == ready_lo[i]);
            memReadValid = 1'($urandom_range(1, 0));
            memReadData = $urandom;
            if (wr && abort_lane == i && c == 0) begin
               abort_now();
               return;
            end
            #1;
            chk_eq("iss_req",   memRequest,     1'b1);
            chk_eq("iss_we",    memWriteEnable, wr);
            chk_eq("iss_addr",  memAddress,     addr);
            chk_eq("iss_wdata", memWriteData,   wdata[i*8 +: 8]);
            chk_eq("iss_done",  doneM,          1'b0);
            if (stallM) stall_cnt++;
            seen_addr[i] = memAddress;
            seen_data[i] = memWriteData;
         end
         if (!wr) begin
            for (int c = 1; c <= rd_lat[i]; c++) begin
               @(negedge clk);
               scramble();
               startM = hold_start;
               memReady = 1'($urandom_range(1, 0));
               memReadValid = (c == rd_lat[i]);
               memReadData = (c == rd_lat[i]) ? rd_byte[i] : 8'($urandom);
               if (abort_lane == i && c == 1) begin
                  abort_now();
                  return;
               end
               #1;
               chk_eq("wait_req",  memRequest, 1'b0);
               chk_eq("wait_done", doneM,      1'b0);
               if (stallM) stall_cnt++;
               if (c == rd_lat[i]) new_vrd[i*8 +: 8] = rd_byte[i];
            end
         end
      end

      @(negedge clk);
      startM = hold_start;
      memReady = 1'($urandom_range(1, 0)); memReadValid = 1'($urandom_range(1, 0));
      #1;
      chk_eq("done_pulse", doneM,      1'b1);
      chk_eq("done_stall", stallM,     1'b0);
      chk_eq("done_req",   memRequest, 1'b0);
      chk_eq("done_vrd",   vectorReadDataWB, new_vrd);
      chk_eq("stall_cnt",  32'(stall_cnt), 32'(exp_stall));
      exp_vrd = new_vrd;

      @(negedge clk);
      startM = 1'b0;
      memReady = 1'($urandom_range(1, 0)); memReadValid = 1'($urandom_range(1, 0));
      #1;
      chk_eq("idle_done",  doneM,      1'b0);
      chk_eq("idle_req",   memRequest, 1'b0);
      chk_eq("idle_stall", stallM,     1'b0);
      chk_eq("idle_vrd",   vectorReadDataWB, exp_vrd);
   endtask

   task automatic set_timing(input int r0, input int r1, input int r2, input int r3, input int lat);
      ready_lo[0] = r0; ready_lo[1] = r1; ready_lo[2] = r2; ready_lo[3] = r3;
      for (int i = 0; i < 4; i++) rd_lat[i] = lat;
   endtask

   initial begin
      logic [31:0] exp_wrap[4];
      logic [7:0]  st_bytes[4];
      rst_n = 1'b0; startM = 1'b0; writeM = 1'b0; baseAddressM = 32'h0; strideM = 32'h0;
      vectorWriteDataM = 32'h0; memReady = 1'b0; memReadValid = 1'b0; memReadData = 8'h0;
      repeat (3) @(negedge clk);
      #1;
      chk_eq("rst_req",   memRequest,       1'b0);
      chk_eq("rst_we",    memWriteEnable,   1'b0);
      chk_eq("rst_addr",  memAddress,       32'h0);
      chk_eq("rst_stall", stallM,           1'b0);
      chk_eq("rst_done",  doneM,            1'b0);
      chk_eq("rst_vrd",   vectorReadDataWB, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed store, unit stride
      set_timing(0, 0, 0, 0, 1);
      run_op(1'b1, 32'h100, 32'h1, 32'h44332211, 1'b0, -1);
      st_bytes[0] = 8'h11; st_bytes[1] = 8'h22; st_bytes[2] = 8'h33; st_bytes[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         chk_eq("st_addr", seen_addr[i], 32'h100 + 32'(i));
         chk_eq("st_data", seen_data[i], st_bytes[i]);
      end

      // Directed load with 1-cycle read latency
      for (int i = 0; i < 4; i++) rd_byte[i] = 8'hA0 + 8'(i);
      run_op(1'b0, 32'h200, 32'h1, 32'h0, 1'b0, -1);
      chk_eq("ld_vrd", vectorReadDataWB, 32'hA3A2A1A0);

      // Backpressure on lane 2 of a store
      set_timing(0, 0, 3, 0, 1);
      run_op(1'b1, 32'h300, 32'h1, 32'hDDCCBBAA, 1'b0, -1);
      chk_eq("bp_vrd_kept", vectorReadDataWB, 32'hA3A2A1A0);

      // Address wrap
      set_timing(0, 0, 0, 0, 1);
      run_op(1'b1, 32'hFFFFFFFE, 32'h2, 32'h87654321, 1'b0, -1);
`ifdef VMEM_STRIDE_EN
      exp_wrap[0] = 32'hFFFFFFFE; exp_wrap[1] = 32'h0; exp_wrap[2] = 32'h2; exp_wrap[3] = 32'h4;
`else
      exp_wrap[0] = 32'hFFFFFFFE; exp_wrap[1] = 32'hFFFFFFFF; exp_wrap[2] = 32'h0; exp_wrap[3] = 32'h1;
`endif
      for (int i = 0; i < 4; i++) chk_eq("wrap_addr", seen_addr[i], exp_wrap[i]);

      // Reset during WAIT_READ of lane 1, then a normal load
      for (int i = 0; i < 4; i++) rd_byte[i] = 8'h50 + 8'(i);
      run_op(1'b0, 32'h400, 32'h1, 32'h0, 1'b0, 1);
      run_op(1'b0, 32'h500, 32'h1, 32'h0, 1'b0, -1);
      chk_eq("post_rst_vrd", vectorReadDataWB, 32'h53525150);

      // Reset during ISSUE of lane 2 of a store
      run_op(1'b1, 32'h600, 32'h1, 32'h12345678, 1'b0, 2);

      // startM held high through DONE
      run_op(1'b1, 32'h700, 32'h1, 32'hCAFEF00D, 1'b1, -1);
      run_op(1'b0, 32'h800, 32'h3, 32'h0, 1'b1, -1);

      // Randomized operations
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < 4; i++) begin
            ready_lo[i] = $urandom_range(2, 0);
            rd_lat[i]   = $urandom_range(3, 1);
            rd_byte[i]  = 8'($urandom);
         end
         run_op(1'($urandom_range(1, 0)), $urandom, $urandom, $urandom,
                1'($urandom_range(1, 0)), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
